// File: rtl/fft_pkg.sv
// Shared constants, types and twiddle table for the radix-2 DIT FFT sequencer.
package fft_pkg;

    // Default transform size and write-back latency.
    localparam int N     = 32;
    localparam int LOG2N = 5;
    localparam int PIPE  = 2;

    // Packed complex sample / coefficient in Q1.15: {re, im}.
    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } cplx_t;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fft_state_t;

    // W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N) for k = 0..N/2-1, packed {re, im}.
    // The exact -1.0 at k = N/4 uses the full negative code 0x8000.
    localparam logic [31:0] TWIDDLE [N/2] = '{
        32'h7fff_0000, 32'h7d8a_e707, 32'h7642_cf04, 32'h6a6e_b8e3,
        32'h5a82_a57e, 32'h471d_9592, 32'h30fc_89be, 32'h18f9_8276,
        32'h0000_8000, 32'he707_8276, 32'hcf04_89be, 32'hb8e3_9592,
        32'ha57e_a57e, 32'h9592_b8e3, 32'h89be_cf04, 32'h8276_e707
    };

    // Twiddle lookup returning the coefficient as a complex struct.
    function automatic cplx_t twiddle(input logic [LOG2N-2:0] k);
        cplx_t w;
        w.re = TWIDDLE[k][31:16];
        w.im = TWIDDLE[k][15:0];
        return w;
    endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational butterfly address map: (stage, j) -> (addr_a, addr_b, tw_idx).
import fft_pkg::*;

module fft_addr_gen #(
    parameter int LOG2N = fft_pkg::LOG2N
) (
    input  logic [$clog2(LOG2N)-1:0] stage_i,
    input  logic [LOG2N-2:0]         j_i,
    output logic [LOG2N-1:0]         addr_a_o,
    output logic [LOG2N-1:0]         addr_b_o,
    output logic [LOG2N-2:0]         tw_idx_o
);

    localparam int SW = $clog2(LOG2N);

    logic [LOG2N-1:0] j_ext;
    logic [LOG2N-1:0] half;
    logic [LOG2N-1:0] pos;
    logic [LOG2N-1:0] grp;
    logic [SW-1:0]    tw_shamt;

    // Split j into group/position within the current span and form the pair.
    always_comb begin
        j_ext    = {1'b0, j_i};
        half     = {{(LOG2N-1){1'b0}}, 1'b1} << stage_i;
        pos      = j_ext & (half - {{(LOG2N-1){1'b0}}, 1'b1});
        grp      = j_ext >> stage_i;
        // Group base is grp * 2 * half; pos < half so OR is an add.
        addr_a_o = ((grp << stage_i) << 1) | pos;
        addr_b_o = addr_a_o + half;
        // Twiddle stride shrinks by two each stage: k = pos * (N/2) / half.
        tw_shamt = SW'(LOG2N - 1) - stage_i;
        tw_idx_o = pos[LOG2N-2:0] << tw_shamt;
    end

endmodule

// File: rtl/fft_ctrl.sv
// Stage/butterfly sequencer for the in-place radix-2 DIT FFT.
// Issues read addresses + twiddle index per butterfly and replays them as
// write-back addresses PIPE cycles later; drains between stages so the last
// writes of one stage land before the next stage starts reading.
import fft_pkg::*;

module fft_ctrl #(
    parameter int N     = fft_pkg::N,
    parameter int LOG2N = fft_pkg::LOG2N,
    parameter int PIPE  = fft_pkg::PIPE
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(LOG2N)-1:0] stage,
    output logic                     rd_en,
    output logic [LOG2N-1:0]         rd_addr_a,
    output logic [LOG2N-1:0]         rd_addr_b,
    output logic [LOG2N-2:0]         tw_idx,
    output logic                     wr_en,
    output logic [LOG2N-1:0]         wr_addr_a,
    output logic [LOG2N-1:0]         wr_addr_b
);

    localparam int SW = $clog2(LOG2N);
    localparam int JW = LOG2N - 1;
    localparam int DW = (PIPE > 1) ? $clog2(PIPE) : 1;

    localparam logic [JW-1:0] J_LAST = JW'(N / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
    localparam logic [DW-1:0] D_LAST = DW'(PIPE - 1);

    fft_state_t state_q, state_d;
    logic [SW-1:0] stage_q, stage_d;
    logic [JW-1:0] j_q, j_d;
    logic [DW-1:0] drain_q, drain_d;

    logic busy_d, done_d, rd_en_d;
    logic busy_q, done_q, rd_en_q;
    logic [LOG2N-1:0] rd_addr_a_q, rd_addr_b_q;
    logic [LOG2N-2:0] tw_idx_q;

    logic [LOG2N-1:0] gen_addr_a, gen_addr_b;
    logic [LOG2N-2:0] gen_tw_idx;

    // Write-back delay line; index 0 is the issued read, index PIPE the write.
    logic [PIPE:0]                wb_en_chain;
    logic [PIPE:0][LOG2N-1:0]     wb_a_chain;
    logic [PIPE:0][LOG2N-1:0]     wb_b_chain;

    // Addresses are generated from the next-state counters so they register
    // alongside rd_en and appear in the same cycle as the strobe.
    fft_addr_gen #(
        .LOG2N (LOG2N)
    ) u_addr_gen (
        .stage_i  (stage_d),
        .j_i      (j_d),
        .addr_a_o (gen_addr_a),
        .addr_b_o (gen_addr_b),
        .tw_idx_o (gen_tw_idx)
    );

    // State, stage, butterfly and drain counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
            j_q     <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            j_q     <= j_d;
            drain_q <= drain_d;
        end
    end

    // Next-state logic; terminal counter values drive every transition so no
    // counter ever wraps.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        j_d     = j_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    stage_d = '0;
                    j_d     = '0;
                end
            end
            ST_RUN: begin
                if (j_q == J_LAST) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    j_d = j_q + JW'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_q == D_LAST) begin
                    if (stage_q == S_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                        stage_d = stage_q + SW'(1);
                        j_d     = '0;
                    end
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        rd_en_d = (state_d == ST_RUN);
        busy_d  = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d  = (state_d == ST_DONE);
    end

    // Registered handshake and read-side outputs; addresses hold while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            tw_idx_q    <= '0;
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_en_q <= rd_en_d;
            if (rd_en_d) begin
                rd_addr_a_q <= gen_addr_a;
                rd_addr_b_q <= gen_addr_b;
                tw_idx_q    <= gen_tw_idx;
            end
        end
    end

    assign wb_en_chain[0] = rd_en_q;
    assign wb_a_chain[0]  = rd_addr_a_q;
    assign wb_b_chain[0]  = rd_addr_b_q;

    genvar gi;
    generate
        for (gi = 0; gi < PIPE; gi++) begin : g_wb_pipe
            logic             en_q;
            logic [LOG2N-1:0] a_q;
            logic [LOG2N-1:0] b_q;

            // One write-back delay slot; reset flushes it so no stale write survives.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    en_q <= 1'b0;
                    a_q  <= '0;
                    b_q  <= '0;
                end else begin
                    en_q <= wb_en_chain[gi];
                    a_q  <= wb_a_chain[gi];
                    b_q  <= wb_b_chain[gi];
                end
            end

            assign wb_en_chain[gi+1] = en_q;
            assign wb_a_chain[gi+1]  = a_q;
            assign wb_b_chain[gi+1]  = b_q;
        end
    endgenerate

    assign busy      = busy_q;
    assign done      = done_q;
    assign stage     = stage_q;
    assign rd_en     = rd_en_q;
    assign rd_addr_a = rd_addr_a_q;
    assign rd_addr_b = rd_addr_b_q;
    assign tw_idx    = tw_idx_q;
    assign wr_en     = wb_en_chain[PIPE];
    assign wr_addr_a = wb_a_chain[PIPE];
    assign wr_addr_b = wb_b_chain[PIPE];

endmodule

// File: tb/tb_fft_ctrl.sv
// Self-checking bench for fft_ctrl: frame-level reference model, spurious
// start pulses, and a mid-frame asynchronous reset.
module tb_fft_ctrl;

    localparam int N     = 32;
    localparam int LOG2N = 5;
    localparam int PIPE  = 2;
    localparam int SW    = $clog2(LOG2N);
    localparam int PER   = N / 2 + PIPE;
    localparam int TOTAL = LOG2N * PER;

    logic             clk;
    logic             reset;
    logic             start;
    logic             busy;
    logic             done;
    logic [SW-1:0]    stage;
    logic             rd_en;
    logic [LOG2N-1:0] rd_addr_a;
    logic [LOG2N-1:0] rd_addr_b;
    logic [LOG2N-2:0] tw_idx;
    logic             wr_en;
    logic [LOG2N-1:0] wr_addr_a;
    logic [LOG2N-1:0] wr_addr_b;

    int vectors;
    int miscompares;
    int cyc_t;

    fft_ctrl #(
        .N     (N),
        .LOG2N (LOG2N),
        .PIPE  (PIPE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .stage     (stage),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_idx    (tw_idx),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s t=%0d: observed %0h expected %0h", tag, cyc_t, obs, expv);
        end
    endtask

    // Reference: what the read port should issue in busy cycle t (1-based,
    // counted from the cycle after the accepted start).
    function automatic void exp_rd(input int t, output bit en, output int s,
                                   output int a, output int b, output int tw);
        int r, half, pos;
        en = 0; s = 0; a = 0; b = 0; tw = 0;
        if (t >= 1 && t <= TOTAL) begin
            s = (t - 1) / PER;
            r = (t - 1) % PER;
            if (r < N / 2) begin
                en   = 1;
                half = 1 << s;
                pos  = r % half;
                a    = (r / half) * 2 * half + pos;
                b    = a + half;
                tw   = pos * ((N / 2) / half);
            end
        end
    endfunction

    task automatic chk_idle();
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_rd_en", rd_en, 0);
        chk("idle_wr_en", wr_en, 0);
    endtask

    // Runs one frame from a start pulse; called just after a rising edge.
    task automatic run_frame(input bit noise);
        int rd_cnt, wr_cnt, done_cnt;
        bit en, wen;
        int s, a, b, tw, ws, wa, wb, wtw;
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 1; t <= TOTAL + 3; t++) begin
            @(negedge clk);
            cyc_t = t;
            exp_rd(t, en, s, a, b, tw);
            exp_rd(t - PIPE, wen, ws, wa, wb, wtw);
            chk("busy", busy, (t <= TOTAL) ? 1 : 0);
            chk("done", done, (t == TOTAL + 1) ? 1 : 0);
            chk("rd_en", rd_en, en);
            chk("wr_en", wr_en, wen);
            if (t <= TOTAL) chk("stage", stage, s);
            if (en) begin
                chk("rd_addr_a", rd_addr_a, a);
                chk("rd_addr_b", rd_addr_b, b);
                chk("tw_idx", tw_idx, tw);
            end
            if (wen) begin
                chk("wr_addr_a", wr_addr_a, wa);
                chk("wr_addr_b", wr_addr_b, wb);
            end
            rd_cnt   += int'(rd_en);
            wr_cnt   += int'(wr_en);
            done_cnt += int'(done);
            @(posedge clk); #1;
            // Spurious starts only land in busy or done cycles, which must ignore them.
            if (noise && (t + 1 <= TOTAL + 1))
                start = ((t + 1 == TOTAL + 1) || (t + 1 == 45) || ($urandom_range(0, 7) == 0));
            else
                start = 1'b0;
        end
        start = 1'b0;
        chk("rd_count", rd_cnt, LOG2N * N / 2);
        chk("wr_count", wr_cnt, LOG2N * N / 2);
        chk("done_count", done_cnt, 1);
        $display("frame noise=%0d: rd=%0d wr=%0d done=%0d", noise, rd_cnt, wr_cnt, done_cnt);
    endtask

    task automatic idle_gap(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            cyc_t = -1;
            chk_idle();
        end
        @(posedge clk); #1;
    endtask

    // Starts a frame and asserts reset in the middle of busy cycle 40.
    task automatic abort_frame();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            cyc_t = t;
            chk("abort_busy", busy, 1);
            if (t < 40) begin
                @(posedge clk); #1;
            end
        end
        reset = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_rd_en", rd_en, 0);
        chk("arst_wr_en", wr_en, 0);
        chk("arst_stage", stage, 0);
        chk("arst_rd_addr_a", rd_addr_a, 0);
        chk("arst_rd_addr_b", rd_addr_b, 0);
        chk("arst_tw_idx", tw_idx, 0);
        chk("arst_wr_addr_a", wr_addr_a, 0);
        chk("arst_wr_addr_b", wr_addr_b, 0);
        $display("abort: reset asserted at busy cycle 40");
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        idle_gap(6);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc_t       = 0;
        reset       = 1'b1;
        start       = 1'b0;

        // Reset dominates a start presented while it is held.
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_stage", stage, 0);
        chk("rst_rd_addr_a", rd_addr_a, 0);
        chk("rst_rd_addr_b", rd_addr_b, 0);
        chk("rst_tw_idx", tw_idx, 0);
        chk("rst_wr_addr_a", wr_addr_a, 0);
        chk("rst_wr_addr_b", wr_addr_b, 0);
        $display("reset: outputs checked with start held high");
        @(posedge clk); #1;
        start = 1'b0;
        reset = 1'b0;
        idle_gap(2);

        run_frame(1'b0);
        for (int f = 0; f < 3; f++) begin
            idle_gap($urandom_range(1, 5));
            run_frame(1'b1);
        end

        idle_gap($urandom_range(1, 3));
        abort_frame();
        run_frame(1'b0);
        idle_gap(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fft_ctrl.md
Name: fft_ctrl

Overview:
Sequencer for the in-place radix-2 DIT FFT built around the butterflyunit datapath, where A_f = A + W·B and B_f = A − W·B on packed {real,imag} 16-bit Q1.15 operands.
- Walks LOG2N stages of N/2 butterflies each.
- Per butterfly, issues dual read addresses to the sample RAM and a twiddle index to the twiddle ROM, then issues the matching write-back addresses PIPE cycles later.
- Input samples are already in bit-reversed order in RAM; output is natural order.
- A start/busy/done handshake links it to the frame loader and the magnitude/display stage.

Parameters:
N, 32, FFT points; power of two, at least 4
LOG2N, 5, log2(N)
PIPE, 2, cycles from read issue to write-back (1 RAM/ROM read latency + 1 butterfly output register); at least 1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle request to transform the frame in RAM; honoured only in IDLE
busy  out  1  high in RUN and DRAIN; controller owns the RAM ports
done  out  1  one-cycle pulse when the final write-back has completed
stage  out  $clog2(LOG2N)  stage currently being read (0..LOG2N-1)
rd_en  out  1  read strobe for RAM port A/B and the twiddle ROM
rd_addr_a  out  LOG2N  RAM address of butterfly input A
rd_addr_b  out  LOG2N  RAM address of butterfly input B
tw_idx  out  LOG2N-1  twiddle ROM index k for W_N^k (0..N/2-1)
wr_en  out  1  write strobe for RAM port A/B
wr_addr_a  out  LOG2N  write address for A_f
wr_addr_b  out  LOG2N  write address for B_f

Behaviour:
- Reset (async, dominates start):
  - State goes to IDLE.
  - busy=0, done=0, rd_en=0, wr_en=0, stage=0, all addresses and tw_idx = 0.
  - The write-delay pipeline is flushed, so no stale wr_en appears after reset.
  - Reset mid-frame abandons the frame and leaves RAM contents undefined.
- FSM states:
  - IDLE: start=1 at edge k moves to RUN; stage=0, j=0.
  - RUN: rd_en=1 every cycle with j incrementing. After j=N/2-1, go to DRAIN.
  - DRAIN: lasts PIPE cycles with rd_en=0, so the last writes of the stage land before the next stage reads (RAW hazard). Then, if stage<LOG2N-1, stage++ and return to RUN with j=0; otherwise go to DONE.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- start asserted in RUN, DRAIN or DONE is ignored and not queued.
- Registered outputs:
  - First rd_en occurs in cycle k+1.
  - Busy time is LOG2N·(N/2+PIPE) cycles.
  - done is high in cycle k+1+LOG2N·(N/2+PIPE); for defaults, 90 busy cycles and done at k+91.
- Address generation for stage s and butterfly j:
  - half = 2^s, pos = j & (half-1), grp = j >> s
  - rd_addr_a = grp·2·half + pos
  - rd_addr_b = rd_addr_a + half
  - tw_idx = pos << (LOG2N-1-s)
- Write-back:
  - wr_en, wr_addr_a and wr_addr_b are rd_en, rd_addr_a and rd_addr_b delayed exactly PIPE cycles through a shift register.
  - wr_en count per stage = N/2, with no gaps and no duplicates.
- tw_idx is issued in the same cycle as the read addresses, so the ROM output aligns with the RAM read data.
- stage changes only on the DRAIN→RUN transition.
- Wrap-around: the j counter and stage counter never overflow; the terminal values drive the transitions.
- Read and write addresses within one cycle of RUN never collide, because every pair is touched once per stage.

Decomposition:
- Package fft_pkg holds:
  - N, LOG2N
  - cplx_t typedef: packed struct {logic signed [15:0] re, im}
  - the twiddle table as Q1.15 constants for k=0..N/2-1, e.g. k=0 → 7fff_0000, k=8 → 0000_8000 for N=32
  - the FSM state enum
- Sub-module fft_addr_gen: purely combinational map from (stage, j) to (addr_a, addr_b, tw_idx). It is reusable by the bench as a reference model.

Test Plan:
- Reset then single start pulse → busy rises the cycle after start; exactly 5×16=80 rd_en and 80 wr_en cycles; done single pulse at start+91; busy=0 in the done cycle.
- Stage 0 address check → j=0: a=0,b=1,tw=0; j=1: a=2,b=3,tw=0. Stage 1, j=1 → a=1,b=3,tw=8.
- Stage 2, j=5 → a=9,b=13,tw=4. Stage 4, j=5 → a=5,b=21,tw=5. Each wr_addr equals the rd_addr from exactly 2 cycles earlier.
- Stage boundary → 2 cycles of rd_en=0 between stages; the last wr_en of stage s precedes the first rd_en of stage s+1 by at least 1 cycle; stage increments then.
- start re-pulsed mid-frame and in the done cycle → ignored; total cycle count unchanged; no second done.
- reset asserted at the 40th busy cycle → all outputs 0 asynchronously; no wr_en after release; a fresh start runs a full 90-cycle frame.
